sync_fifo_flags: RTL and testbench
==================================

// Module: sync_fifo_flags
// PURPOSE
//   Single-clock parametrised FIFO, the successor of the basic write/read FIFO.
//   Adds fill count, programmable almost-full/almost-empty thresholds, and an optional
//   first-word-fall-through (FWFT) read mode. Also adds synchronous flush and sticky
//   overflow/underflow error flags. Sits between producer/consumer stages on one clock domain.
// PARAMETERS
//   DATA_WIDTH  8   data word width in bits (>=1)
//   FIFO_DEPTH  16  number of entries; power of two, >=4
//   AF_THRESH   14  almost_full asserted when count >= AF_THRESH (1..FIFO_DEPTH)
//   AE_THRESH   2   almost_empty asserted when count <= AE_THRESH (0..FIFO_DEPTH-1)
//   FWFT        0   0 = registered read, 1 cycle latency; 1 = first-word-fall-through
//   (ADDR_W = $clog2(FIFO_DEPTH), local)
// PORTS
//   clk           in   1             clock, all logic on rising edge
//   rst           in   1             synchronous, active-high reset
//   flush         in   1             synchronous clear of pointers/count (storage untouched)
//   clr_err       in   1             clears overflow/underflow sticky flags
//   write_en      in   1             write request
//   data_in       in   DATA_WIDTH    write data
//   read_en       in   1             read request (FWFT=1: pop/acknowledge of head word)
//   data_out      out  DATA_WIDTH    read data
//   data_valid    out  1             FWFT=0: data_out updated this cycle; FWFT=1: equals !empty
//   empty         out  1             count == 0
//   full          out  1             count == FIFO_DEPTH
//   almost_empty  out  1             count <= AE_THRESH
//   almost_full   out  1             count >= AF_THRESH
//   count         out  ADDR_W+1      current occupancy, 0..FIFO_DEPTH
//   overflow      out  1             sticky: write_en seen while full
//   underflow     out  1             sticky: read_en seen while empty
// BEHAVIOUR
//   - Reset (rst=1 at posedge): wr_ptr=rd_ptr=0, count=0, data_out=0, data_valid=0,
//     empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
//     Applies mid-operation; contents discarded; storage array is not cleared.
//   - Write accepted iff write_en && !full: mem[wr_ptr]<=data_in, wr_ptr wraps DEPTH-1 -> 0.
//   - Read accepted iff read_en && !empty: rd_ptr wraps DEPTH-1 -> 0.
//   - Acceptance uses pre-edge flags. Simultaneous accepted write+read: count unchanged.
//     When full, read accepted and write rejected. When empty, write accepted and read rejected.
//     Never write-through-when-empty.
//   - count: +1 on write-only, -1 on read-only, else hold; never exceeds DEPTH or goes below 0.
//   - All flags are registered and derived from next-count; valid the cycle after the edge.
//   - FWFT=0: on accepted read, data_out <= mem[rd_ptr] and data_valid=1 for one cycle.
//     Otherwise data_out holds its last value and data_valid=0.
//   - FWFT=1: data_out = mem[rd_ptr] whenever !empty (combinational read of head).
//     data_valid = !empty. An accepted read exposes the next word the following cycle.
//   - overflow <= 1 on write_en && full; underflow <= 1 on read_en && empty.
//     Both stay set until clr_err or rst. clr_err and a new error in the same cycle: set wins.
//   - flush: priority over write/read that cycle. Pointers and count go to 0, flags return to
//     reset values, data_valid=0, and the data_out register holds.
//     Sticky error flags are not cleared by flush.
//   - Priority: rst > flush > normal operation.
// TESTING  (DATA_WIDTH=8, FIFO_DEPTH=16, AF=14, AE=2, both FWFT values)
//   1. rst 2 cycles -> empty=1 full=0 count=0 almost_empty=1 data_out=0 overflow=underflow=0.
//   2. Write 10..25 back-to-back, then 1 extra write -> full=1 after 16th, almost_full from
//      count 14, count=16, overflow=1, data at mem unchanged by extra write.
//   3. Read 16 -> data 10..25 in order (FWFT=0: one cycle after read_en with data_valid;
//      FWFT=1: head visible before read_en). Ends empty=1; an extra read sets underflow=1
//      and data_out holds 25.
//   4. Fill to 8, then 5 cycles write 100..104 + read -> count stays 8, reads return the
//      oldest words in order. Full FIFO with write+read -> count 15, write rejected, overflow=1.
//   5. Pointer wrap: 3 rounds of write 12/read 12 -> no data mismatch, count returns to 0.
//   6. Fill to 5, assert flush with write_en=1 -> count=0, empty=1, write ignored.
//     rst asserted mid-fill -> reset values next cycle. clr_err -> overflow=underflow=0.

Source files
------------

// File: rtl/sync_fifo_flags.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_flags
//  Description : Single-clock FIFO with fill count, almost-full/almost-empty
//                thresholds, optional first-word-fall-through read, synchronous
//                flush and sticky overflow/underflow error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_THRESH  = 14,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 0,
  localparam int ADDR_W    = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  clr_err,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_W:0]       count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int               c_cnt_w = ADDR_W + 1;
  localparam logic [ADDR_W:0]  c_depth = c_cnt_w'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]  c_af    = c_cnt_w'(AF_THRESH);
  localparam logic [ADDR_W:0]  c_ae    = c_cnt_w'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]       count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  almost_empty_q, almost_empty_d;
  logic                  almost_full_q, almost_full_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_mem_we;

  // Acceptance is decided from the registered (pre-edge) flags; flush discards both requests.
  assign w_wr_acc = write_en & ~full_q & ~flush;
  assign w_rd_acc = read_en & ~empty_q & ~flush;
  assign w_mem_we = w_wr_acc & ~rst;

  // Next-state computation for pointers, occupancy, flags, read register and error flags.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (w_rd_acc) begin
        rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
        data_out_d = mem[rd_ptr_q];
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   count_d = count_q + c_cnt_w'(1);
        2'b01:   count_d = count_q - c_cnt_w'(1);
        default: count_d = count_q;
      endcase
    end

    empty_d        = (count_d == '0);
    full_d         = (count_d == c_depth);
    almost_empty_d = (count_d <= c_ae);
    almost_full_d  = (count_d >= c_af);

    // Registered mode pulses valid for the cycle the read word lands; FWFT mirrors !empty.
    data_valid_d = (FWFT != 0) ? (count_d != '0) : w_rd_acc;

    // A new error in the same cycle as clr_err keeps the flag set.
    overflow_d  = (write_en & full_q & ~flush)  | (overflow_q  & ~clr_err);
    underflow_d = (read_en  & empty_q & ~flush) | (underflow_q & ~clr_err);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      data_out_q     <= '0;
      data_valid_q   <= 1'b0;
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      almost_empty_q <= 1'b1;
      almost_full_q  <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      data_out_q     <= data_out_d;
      data_valid_q   <= data_valid_d;
      empty_q        <= empty_d;
      full_q         <= full_d;
      almost_empty_q <= almost_empty_d;
      almost_full_q  <= almost_full_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  // Storage array has no reset; only accepted writes touch it.
  always_ff @(posedge clk) begin
    if (w_mem_we) mem[wr_ptr_q] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is shown directly; when empty, the last popped word stays visible.
      assign data_out = empty_q ? data_out_q : mem[rd_ptr_q];
    end else begin : g_reg
      assign data_out = data_out_q;
    end
  endgenerate

  assign data_valid   = data_valid_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = almost_empty_q;
  assign almost_full  = almost_full_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_flags.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_fifo_flags
//  Description : Self-checking bench for sync_fifo_flags; a registered-read and
//                an FWFT instance share one stimulus stream and a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_flags;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          clr_err = 1'b0;
  logic          write_en = 1'b0;
  logic          read_en = 1'b0;
  logic [DW-1:0] data_in = '0;

  logic [DW-1:0] r_dout, f_dout;
  logic          r_valid, f_valid, r_empty, f_empty, r_full, f_full;
  logic          r_ae, f_ae, r_af, f_af, r_ovf, f_ovf, r_unf, f_unf;
  logic [4:0]    r_count, f_count;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AF_THRESH(AF),
                    .AE_THRESH(AE), .FWFT(0)) u_dut_reg (
    .clk(clk), .rst(rst), .flush(flush), .clr_err(clr_err),
    .write_en(write_en), .data_in(data_in), .read_en(read_en),
    .data_out(r_dout), .data_valid(r_valid), .empty(r_empty), .full(r_full),
    .almost_empty(r_ae), .almost_full(r_af), .count(r_count),
    .overflow(r_ovf), .underflow(r_unf));

  sync_fifo_flags #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AF_THRESH(AF),
                    .AE_THRESH(AE), .FWFT(1)) u_dut_fwft (
    .clk(clk), .rst(rst), .flush(flush), .clr_err(clr_err),
    .write_en(write_en), .data_in(data_in), .read_en(read_en),
    .data_out(f_dout), .data_valid(f_valid), .empty(f_empty), .full(f_full),
    .almost_empty(f_ae), .almost_full(f_af), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf));

  // Reference model: the FIFO contents as a queue plus the observable side state.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_reg[$];
  logic [DW-1:0] exp_fwft[$];
  logic [DW-1:0] m_last = '0;
  bit            m_ovf = 1'b0, m_unf = 1'b0, m_vld = 1'b0;
  bit            chk_en = 1'b0;
  int            n_tests = 0, n_fail = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: flags and data compared against the model at every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      int       mc;
      logic [DW-1:0] head;
      mc   = mq.size();
      head = (mc != 0) ? mq[0] : m_last;
      check("r_count", 32'(r_count), mc);
      check("f_count", 32'(f_count), mc);
      check("r_empty", 32'(r_empty), 32'(mc == 0));
      check("f_empty", 32'(f_empty), 32'(mc == 0));
      check("r_full",  32'(r_full),  32'(mc == DEPTH));
      check("f_full",  32'(f_full),  32'(mc == DEPTH));
      check("r_aempty", 32'(r_ae), 32'(mc <= AE));
      check("f_aempty", 32'(f_ae), 32'(mc <= AE));
      check("r_afull",  32'(r_af), 32'(mc >= AF));
      check("f_afull",  32'(f_af), 32'(mc >= AF));
      check("r_overflow",  32'(r_ovf), 32'(m_ovf));
      check("f_overflow",  32'(f_ovf), 32'(m_ovf));
      check("r_underflow", 32'(r_unf), 32'(m_unf));
      check("f_underflow", 32'(f_unf), 32'(m_unf));
      check("r_valid", 32'(r_valid), 32'(m_vld));
      check("r_dout",  32'(r_dout), 32'(m_last));
      check("f_valid", 32'(f_valid), 32'(mc != 0));
      check("f_dout",  32'(f_dout), 32'(head));
      // Scoreboard pops: registered mode on the valid pulse, FWFT on the pop handshake.
      if (r_valid) begin
        if (exp_reg.size() == 0) check("r_sb_unexpected", 32'(r_valid), 0);
        else check("r_sb_data", 32'(r_dout), 32'(exp_reg.pop_front()));
      end
      if (f_valid && read_en && !flush && !rst) begin
        if (exp_fwft.size() == 0) check("f_sb_unexpected", 32'(f_valid), 0);
        else check("f_sb_data", 32'(f_dout), 32'(exp_fwft.pop_front()));
      end
    end
  end

  // One clock of stimulus; the model advances at the same edge as the DUTs.
  task automatic step(input bit we, input logic [DW-1:0] din, input bit re,
                      input bit fl = 1'b0, input bit ce = 1'b0, input bit rs = 1'b0);
    bit wa, ra, was_full, was_empty;
    write_en = we; data_in = din; read_en = re;
    flush = fl; clr_err = ce; rst = rs;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    wa = we && !was_full;
    ra = re && !was_empty;
    if (ra && !rs && !fl) begin
      exp_reg.push_back(mq[0]);
      exp_fwft.push_back(mq[0]);
    end
    @(posedge clk);
    if (rs) begin
      mq.delete(); exp_reg.delete(); exp_fwft.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_last = '0; m_vld = 1'b0;
    end else if (fl) begin
      mq.delete();
      m_vld = 1'b0;
      m_ovf = m_ovf && !ce;
      m_unf = m_unf && !ce;
    end else begin
      m_ovf = (we && was_full)  || (m_ovf && !ce);
      m_unf = (re && was_empty) || (m_unf && !ce);
      if (ra) m_last = mq.pop_front();
      if (wa) mq.push_back(din);
      m_vld = ra;
    end
    #1;
  endtask

  initial begin
    // 1. Reset
    step(0, '0, 0, 0, 0, 1);
    chk_en = 1'b1;
    step(0, '0, 0, 0, 0, 1);
    step(0, '0, 0);

    // 2. Fill 10..25 then one rejected write
    for (int i = 0; i < DEPTH; i++) step(1, DW'(10 + i), 0);
    step(1, 8'hEE, 0);

    // 3. Drain all 16, then one read on empty
    for (int i = 0; i < DEPTH; i++) step(0, '0, 1);
    step(0, '0, 1);
    step(0, '0, 0);

    // 4. Clear errors, fill to 8, simultaneous write+read, then full with write+read
    step(0, '0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(1, DW'(1 + i), 0);
    for (int i = 0; i < 5; i++) step(1, DW'(100 + i), 1);
    for (int i = 0; i < 8; i++) step(1, DW'(200 + i), 0);
    step(1, 8'h77, 1);
    step(0, '0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) step(0, '0, 1);

    // 5. Pointer wrap
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 12; i++) step(1, DW'($urandom_range(0, 255)), 0);
      for (int i = 0; i < 12; i++) step(0, '0, 1);
    end

    // 6. Flush with a write pending, reset mid-fill, clear errors
    for (int i = 0; i < 5; i++) step(1, DW'(50 + i), 0);
    step(1, 8'h99, 0, 1);
    step(0, '0, 1);
    for (int i = 0; i < 6; i++) step(1, DW'(60 + i), 0);
    step(1, 8'h55, 0, 0, 0, 1);
    step(0, '0, 0);
    step(0, '0, 1);
    step(0, '0, 0, 0, 1);

    // Randomised traffic: fill-biased, then drain-biased
    for (int i = 0; i < 600; i++) begin
      int wp;
      wp = (i < 300) ? 70 : 30;
      step(($urandom_range(0, 99) < wp), DW'($urandom_range(0, 255)),
           ($urandom_range(0, 99) < (100 - wp)),
           ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 4),
           ($urandom_range(0, 199) == 0));
    end

    for (int i = 0; i < DEPTH + 2; i++) step(0, '0, 1);
    step(0, '0, 0);
    step(0, '0, 0);
    check("r_sb_leftover", 32'(exp_reg.size()), 0);
    check("f_sb_leftover", 32'(exp_fwft.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
